// File: rtl/dom_pkg.sv
// dom_pkg
// Shared definitions for the DOM share feeder:
//   - feederState_e : feeder FSM states
//   - NUM_SHARES    : Boolean shares per operand
//   - DRAW_W        : random bits consumed per cycle (4 mask bits + 3 refresh bits)
//   - STEPS_PER_CLK : LFSR steps taken per clock while running
//   - lfsrTaps()    : Fibonacci tap mask for a given LFSR width
package dom_pkg;

    typedef enum logic [1:0] {
        UNSEEDED = 2'd0,
        SEEDING  = 2'd1,
        READY    = 2'd2
    } feederState_e;

    localparam int unsigned NUM_SHARES    = 3;
    localparam int unsigned DRAW_W        = 7;
    localparam int unsigned STEPS_PER_CLK = 8;

    // Bit k of the mask set means polynomial term x^(k+1) feeds the XOR.
    localparam logic [63:0] TAPS_W8  = 64'h0000_0000_0000_00B8;
    localparam logic [63:0] TAPS_W16 = 64'h0000_0000_0000_D008;
    localparam logic [63:0] TAPS_W24 = 64'h0000_0000_00E1_0000;
    localparam logic [63:0] TAPS_W32 = 64'h0000_0000_8020_0003;

    // Widths without a tabulated polynomial fall back to x^W + x + 1.
    function automatic logic [63:0] lfsrTaps(input int unsigned width);
        case (width)
            8:       lfsrTaps = TAPS_W8;
            16:      lfsrTaps = TAPS_W16;
            24:      lfsrTaps = TAPS_W24;
            32:      lfsrTaps = TAPS_W32;
            default: lfsrTaps = (64'd1 << (width - 1)) | 64'd1;
        endcase
    endfunction

endpackage

// File: rtl/dom_lfsr.sv
// dom_lfsr
// Fibonacci LFSR that advances STEPS_PER_CLK steps per clock.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (state clears to 0)
//   load_i     : load seed_i this cycle (takes priority over advance_i)
//   seed_i     : value to load
//   advance_i  : step the register this cycle
//   draw_o     : low DRAW_W bits of the current state
module dom_lfsr
    import dom_pkg::*;
#(
    parameter int unsigned LFSR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic              advance_i,
    output logic [DRAW_W-1:0] draw_o
);

    localparam logic [63:0]       TAPS_ALL = lfsrTaps(LFSR_W);
    localparam logic [LFSR_W-1:0] TAPS     = TAPS_ALL[LFSR_W-1:0];

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;
    logic [LFSR_W-1:0] stepped;

    // Unrolled multi-step advance: each step shifts left and inserts the tap parity.
    always_comb begin
        stepped = state_q;
        for (int unsigned i = 0; i < STEPS_PER_CLK; i++) begin
            stepped = {stepped[LFSR_W-2:0], ^(stepped & TAPS)};
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (advance_i) begin
            state_d = stepped;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign draw_o = state_q[DRAW_W-1:0];

endmodule

// File: rtl/dom_share_feeder.sv
// dom_share_feeder
// Splits unmasked operand bits a, b into three Boolean shares each and supplies
// three refresh bits for a 3-share DOM AND gadget, with randomness from a seeded
// LFSR that must warm up before operands are accepted.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   seed_valid, seed, seed_ready   : seed handshake
//   in_valid, in_a, in_b, in_ready : operand handshake
//   is0, is1, is2                  : share k as {b_k, a_k}
//   refreshing                     : gadget refresh bits r0..r2
//   share_valid                    : shares/refresh valid this cycle
//   os_valid                       : gadget output valid this cycle
//   rng_fail                       : sticky randomness health failure
// Build option DOM_FEEDER_HEALTH_EN: reject zero seeds and watch for a stuck
// generator (repeated draws); without it rng_fail is tied low and a zero seed
// is loaded as 1.
module dom_share_feeder
    import dom_pkg::*;
#(
    parameter int unsigned LFSR_W = 32,
    parameter int unsigned WARMUP = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_valid,
    input  logic [LFSR_W-1:0] seed,
    output logic              seed_ready,
    input  logic              in_valid,
    input  logic              in_a,
    input  logic              in_b,
    output logic              in_ready,
    output logic [1:0]        is0,
    output logic [1:0]        is1,
    output logic [1:0]        is2,
    output logic [2:0]        refreshing,
    output logic              share_valid,
    output logic              os_valid,
    output logic              rng_fail
);

    localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

    feederState_e      state_q, state_d;
    logic [7:0]        warmCnt_q, warmCnt_d;
    logic [DRAW_W-1:0] draw;
    logic              lfsrLoad;
    logic              lfsrAdvance;
    logic [LFSR_W-1:0] lfsrSeed;
    logic              seedAccept;
    logic              inAccept;
    logic [1:0]        shares_d [NUM_SHARES];
    logic [1:0]        shares_q [NUM_SHARES];
    logic [2:0]        refresh_d, refresh_q;
    logic              shareValid_q;
    logic              osValid_q;

`ifdef DOM_FEEDER_HEALTH_EN
    localparam int unsigned REP_LIMIT   = 8;
    localparam logic [2:0]  REP_TRIP_AT = 3'(REP_LIMIT - 2);

    logic              fail_q, fail_d;
    logic [2:0]        repCnt_q, repCnt_d;
    logic [DRAW_W-1:0] prevDraw_q, prevDraw_d;
    logic              repTrip;
`endif

    dom_lfsr #(
        .LFSR_W(LFSR_W)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (lfsrLoad),
        .seed_i   (lfsrSeed),
        .advance_i(lfsrAdvance),
        .draw_o   (draw)
    );

    // A pending seed blocks operands so the reseed wins a same-cycle collision.
    assign seed_ready = (state_q != SEEDING);
    assign in_ready   = (state_q == READY) && !seed_valid;
    assign seedAccept = seed_valid && seed_ready;
    assign inAccept   = in_valid && in_ready;

    // Next state, warm-up counting, LFSR control and (optionally) health tracking.
    // repCnt counts consecutive draws equal to the previous one, so it trips on
    // the draw that makes REP_LIMIT identical values in a row.
    always_comb begin
        state_d     = state_q;
        warmCnt_d   = warmCnt_q;
        lfsrLoad    = 1'b0;
        lfsrSeed    = seed;
        lfsrAdvance = (state_q != UNSEEDED);
`ifdef DOM_FEEDER_HEALTH_EN
        fail_d      = fail_q;
        repCnt_d    = repCnt_q;
        prevDraw_d  = prevDraw_q;
        repTrip     = 1'b0;
`endif

        if (state_q == SEEDING) begin
            warmCnt_d = warmCnt_q + 8'd1;
            if (warmCnt_q == WARM_LAST) begin
                state_d = READY;
            end
        end

`ifdef DOM_FEEDER_HEALTH_EN
        if (state_q != UNSEEDED) begin
            prevDraw_d = draw;
            if (draw == prevDraw_q) begin
                repCnt_d = repCnt_q + 3'd1;
                repTrip  = (repCnt_q == REP_TRIP_AT);
            end else begin
                repCnt_d = '0;
            end
        end
`endif

        if (seedAccept) begin
`ifdef DOM_FEEDER_HEALTH_EN
            // Inverted seed bits guarantee the first draw after a load is not a repeat.
            repCnt_d   = '0;
            prevDraw_d = ~seed[DRAW_W-1:0];
            if (seed == '0) begin
                fail_d  = 1'b1;
                state_d = UNSEEDED;
            end else begin
                fail_d    = 1'b0;
                lfsrLoad  = 1'b1;
                state_d   = SEEDING;
                warmCnt_d = '0;
            end
`else
            // An all-zero LFSR would lock up, so a zero seed becomes 1.
            lfsrLoad = 1'b1;
            if (seed == '0) begin
                lfsrSeed = LFSR_W'(1);
            end
            state_d   = SEEDING;
            warmCnt_d = '0;
`endif
        end

`ifdef DOM_FEEDER_HEALTH_EN
        if (repTrip) begin
            fail_d   = 1'b1;
            repCnt_d = '0;
            state_d  = UNSEEDED;
        end
`endif
    end

    // Share split: two random shares per operand, the third closes the XOR sum.
    // Idle cycles register zeros so stale shares never linger on the outputs.
    always_comb begin
        for (int unsigned k = 0; k < NUM_SHARES; k++) begin
            shares_d[k] = 2'b00;
        end
        refresh_d = 3'b000;
        if (inAccept) begin
            shares_d[0] = {draw[2], draw[0]};
            shares_d[1] = {draw[3], draw[1]};
            shares_d[2] = {in_b ^ draw[2] ^ draw[3], in_a ^ draw[0] ^ draw[1]};
            refresh_d   = draw[6:4];
        end
    end

    // State and output registers; os_valid trails share_valid by the gadget's register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= UNSEEDED;
            warmCnt_q    <= '0;
            shares_q     <= '{default: 2'b00};
            refresh_q    <= '0;
            shareValid_q <= 1'b0;
            osValid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            warmCnt_q    <= warmCnt_d;
            shares_q     <= shares_d;
            refresh_q    <= refresh_d;
            shareValid_q <= inAccept;
            osValid_q    <= shareValid_q;
        end
    end

`ifdef DOM_FEEDER_HEALTH_EN
    // Health monitor registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_q     <= 1'b0;
            repCnt_q   <= '0;
            prevDraw_q <= '0;
        end else begin
            fail_q     <= fail_d;
            repCnt_q   <= repCnt_d;
            prevDraw_q <= prevDraw_d;
        end
    end

    assign rng_fail = fail_q;
`else
    assign rng_fail = 1'b0;
`endif

    assign is0         = shares_q[0];
    assign is1         = shares_q[1];
    assign is2         = shares_q[2];
    assign refreshing  = refresh_q;
    assign share_valid = shareValid_q;
    assign os_valid    = osValid_q;

endmodule

// File: tb/tb_dom_share_feeder.sv
// tb_dom_share_feeder
// Randomized self-checking bench for dom_share_feeder. A behavioural model
// tracks "seeded / warm-up cycles remaining" and the LFSR polynomial, predicts
// every output, and a behavioural DOM AND gadget recombines the shares.
module tb_dom_share_feeder;

    localparam int          LFSR_W   = 32;
    localparam int          WARMUP   = 16;
    localparam logic [31:0] TAP_MASK = 32'h8020_0003;

    logic        clk;
    logic        rst_n;
    logic        seed_valid;
    logic [31:0] seed;
    logic        seed_ready;
    logic        in_valid;
    logic        in_a;
    logic        in_b;
    logic        in_ready;
    logic [1:0]  is0, is1, is2;
    logic [2:0]  refreshing;
    logic        share_valid;
    logic        os_valid;
    logic        rng_fail;

    int compared;
    int mismatched;

    // Model state
    logic [31:0] mLfsr;
    bit          mSeeded;
    int          mWarm;
    bit          mFail;
    logic [1:0]  eIs0, eIs1, eIs2;
    logic [2:0]  eRef;
    bit          eSv, eOsv;
    bit          mAnd1, mAnd2;
    logic [1:0]  rdyObs, rdyExp;
    logic [2:0]  gZ;

    dom_share_feeder #(
        .LFSR_W(LFSR_W),
        .WARMUP(WARMUP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_valid (seed_valid),
        .seed       (seed),
        .seed_ready (seed_ready),
        .in_valid   (in_valid),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_ready   (in_ready),
        .is0        (is0),
        .is1        (is1),
        .is2        (is2),
        .refreshing (refreshing),
        .share_valid(share_valid),
        .os_valid   (os_valid),
        .rng_fail   (rng_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // x^32 + x^22 + x^2 + x + 1, applied eight times.
    function automatic logic [31:0] advance8(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        for (int i = 0; i < 8; i++) begin
            v = {v[30:0], ^(v & TAP_MASK)};
        end
        return v;
    endfunction

    // 3-share DOM AND: each share multiplies its own a-share by all b-shares,
    // with every cross term blinded by a refresh bit shared between two domains.
    function automatic logic [2:0] gadget(input logic [1:0] s0, input logic [1:0] s1,
                                          input logic [1:0] s2, input logic [2:0] r);
        logic a0, a1, a2, b0, b1, b2, z0, z1, z2;
        a0 = s0[0]; a1 = s1[0]; a2 = s2[0];
        b0 = s0[1]; b1 = s1[1]; b2 = s2[1];
        z0 = (a0 & b0) ^ (a0 & b1) ^ r[0] ^ (a0 & b2) ^ r[1];
        z1 = (a1 & b1) ^ (a1 & b0) ^ r[0] ^ (a1 & b2) ^ r[2];
        z2 = (a2 & b2) ^ (a2 & b0) ^ r[1] ^ (a2 & b1) ^ r[2];
        return {z2, z1, z0};
    endfunction

    always @(posedge clk) gZ <= gadget(is0, is1, is2, refreshing);

    task automatic modelReset();
        mLfsr   = '0;
        mSeeded = 1'b0;
        mWarm   = 0;
        mFail   = 1'b0;
        eIs0 = '0; eIs1 = '0; eIs2 = '0; eRef = '0;
        eSv = 1'b0; eOsv = 1'b0; mAnd1 = 1'b0; mAnd2 = 1'b0;
    endtask

    // Drive one cycle of inputs, record handshake readiness, step the model
    // across the clock edge, and leave time 1 unit past the edge.
    task automatic tick(input bit sv, input logic [31:0] sd, input bit iv,
                        input bit a, input bit b);
        logic [6:0] draw;
        bit seedRdy, inRdy;
        seed_valid = sv;
        seed       = sd;
        in_valid   = iv;
        in_a       = a;
        in_b       = b;
        #1;
        seedRdy = !(mSeeded && mWarm > 0);
        inRdy   = mSeeded && (mWarm == 0) && !sv;
        rdyObs  = {seed_ready, in_ready};
        rdyExp  = {seedRdy, inRdy};
        @(posedge clk);
        draw  = mLfsr[6:0];
        eOsv  = eSv;
        mAnd2 = mAnd1;
        if (iv && inRdy) begin
            eIs0  = {draw[2], draw[0]};
            eIs1  = {draw[3], draw[1]};
            eIs2  = {b ^ draw[2] ^ draw[3], a ^ draw[0] ^ draw[1]};
            eRef  = draw[6:4];
            eSv   = 1'b1;
            mAnd1 = a & b;
        end else begin
            eIs0 = '0; eIs1 = '0; eIs2 = '0; eRef = '0;
            eSv   = 1'b0;
            mAnd1 = 1'b0;
        end
        if (sv && seedRdy) begin
`ifdef DOM_FEEDER_HEALTH_EN
            if (sd == 32'd0) begin
                mFail   = 1'b1;
                mSeeded = 1'b0;
            end else begin
                mFail   = 1'b0;
                mLfsr   = sd;
                mSeeded = 1'b1;
                mWarm   = WARMUP;
            end
`else
            mLfsr   = (sd == 32'd0) ? 32'd1 : sd;
            mSeeded = 1'b1;
            mWarm   = WARMUP;
`endif
        end else if (mSeeded) begin
            mLfsr = advance8(mLfsr);
            if (mWarm > 0) mWarm--;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [13:0] obs;
        rst_n = 1'b0;
        seed_valid = 1'b0; seed = '0; in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        obs = {seed_ready, in_ready, is0, is1, is2, refreshing, share_valid, os_valid, rng_fail};
        compared++;
        if (obs !== 14'b10_000000_000_000) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got %b expected %b", obs, 14'b10_000000_000_000);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_warmup();
        int n;
        tick(1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            compared++;
            if ({rdyObs, is0, is1, is2, refreshing, share_valid, os_valid, rng_fail} !==
                {rdyExp, eIs0, eIs1, eIs2, eRef, eSv, eOsv, mFail}) begin
                mismatched++;
                $display("[TB] FAIL warmup_outputs: got %b expected %b",
                         {rdyObs, is0, is1, is2, refreshing, share_valid, os_valid, rng_fail},
                         {rdyExp, eIs0, eIs1, eIs2, eRef, eSv, eOsv, mFail});
            end
            tick(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        compared++;
        if (n != WARMUP) begin
            mismatched++;
            $display("[TB] FAIL warmup_length: got %0d cycles required %0d", n, WARMUP);
        end
    endtask

    task automatic test_back_to_back();
        bit a, b, iv, sv;
        logic [31:0] sd;
        for (int i = 0; i < 84; i++) begin
            if (i < 4) begin
                a = i[0]; b = i[1]; iv = 1'b1; sv = 1'b0;
            end else if (i < 80) begin
                a  = 1'($urandom);
                b  = 1'($urandom);
                iv = ($urandom_range(0, 3) != 0);
                sv = ($urandom_range(0, 31) == 0);
            end else begin
                a = 1'b0; b = 1'b0; iv = 1'b0; sv = 1'b0;
            end
            sd = $urandom | 32'h1;
            tick(sv, sd, iv, a, b);
            compared++;
            if ({rdyObs, is0, is1, is2, refreshing, share_valid, os_valid, rng_fail} !==
                {rdyExp, eIs0, eIs1, eIs2, eRef, eSv, eOsv, mFail}) begin
                mismatched++;
                $display("[TB] FAIL stream_outputs[%0d]: got %b expected %b", i,
                         {rdyObs, is0, is1, is2, refreshing, share_valid, os_valid, rng_fail},
                         {rdyExp, eIs0, eIs1, eIs2, eRef, eSv, eOsv, mFail});
            end
            if (eSv) begin
                compared++;
                if ((is0 ^ is1 ^ is2) !== {b, a}) begin
                    mismatched++;
                    $display("[TB] FAIL share_xor[%0d]: got %b expected %b", i,
                             is0 ^ is1 ^ is2, {b, a});
                end
            end
            if (eOsv) begin
                compared++;
                if ((^gZ) !== mAnd2) begin
                    mismatched++;
                    $display("[TB] FAIL recombined_os[%0d]: got %b expected %b", i, ^gZ, mAnd2);
                end
            end
        end
    endtask

    task automatic test_seed_collision();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            tick(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        tick(1'b1, 32'hC0FF_EE01, 1'b1, 1'b1, 1'b1);
        compared++;
        if ({rdyObs, share_valid} !== 3'b100) begin
            mismatched++;
            $display("[TB] FAIL collision_handshake: got %b expected %b",
                     {rdyObs, share_valid}, 3'b100);
        end
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            tick(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
            compared++;
            if ({rdyObs, share_valid, os_valid} !== {rdyExp, eSv, eOsv}) begin
                mismatched++;
                $display("[TB] FAIL collision_warmup: got %b expected %b",
                         {rdyObs, share_valid, os_valid}, {rdyExp, eSv, eOsv});
            end
            n++;
        end
        compared++;
        if (n != WARMUP) begin
            mismatched++;
            $display("[TB] FAIL collision_length: got %0d cycles required %0d", n, WARMUP);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        logic [11:0] obs;
        tick(1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        modelReset();
        #1;
        obs = {seed_ready, in_ready, share_valid, os_valid, is0, is1, is2};
        compared++;
        if (obs !== 12'b10_00_000000) begin
            mismatched++;
            $display("[TB] FAIL reset_immediate: got %b expected %b", obs, 12'b10_00_000000);
        end
        @(posedge clk);
        #1;
        obs = {seed_ready, in_ready, share_valid, os_valid, is0, is1, is2};
        compared++;
        if (obs !== 12'b10_00_000000) begin
            mismatched++;
            $display("[TB] FAIL reset_inflight: got %b expected %b", obs, 12'b10_00_000000);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
            compared++;
            if ({rdyObs, share_valid, os_valid} !== {rdyExp, eSv, eOsv}) begin
                mismatched++;
                $display("[TB] FAIL reset_unseeded[%0d]: got %b expected %b", i,
                         {rdyObs, share_valid, os_valid}, {rdyExp, eSv, eOsv});
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_zero_seed();
        int n;
        tick(1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
`ifdef DOM_FEEDER_HEALTH_EN
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
            compared++;
            if ({seed_ready, in_ready, rng_fail} !== 3'b101) begin
                mismatched++;
                $display("[TB] FAIL zero_seed_rejected[%0d]: got %b expected %b", i,
                         {seed_ready, in_ready, rng_fail}, 3'b101);
            end
        end
        tick(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        compared++;
        if (rng_fail !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL fail_cleared: got %b expected 0", rng_fail);
        end
`endif
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            tick(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        compared++;
        if (n != WARMUP) begin
            mismatched++;
            $display("[TB] FAIL zero_seed_warmup: got %0d cycles required %0d", n, WARMUP);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 32'd0, 1'b1, 1'(i), 1'(i >> 1));
            compared++;
            if ({rdyObs, is0, is1, is2, refreshing, share_valid, os_valid, rng_fail} !==
                {rdyExp, eIs0, eIs1, eIs2, eRef, eSv, eOsv, mFail}) begin
                mismatched++;
                $display("[TB] FAIL zero_seed_stream[%0d]: got %b expected %b", i,
                         {rdyObs, is0, is1, is2, refreshing, share_valid, os_valid, rng_fail},
                         {rdyExp, eIs0, eIs1, eIs2, eRef, eSv, eOsv, mFail});
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_warmup();
        test_back_to_back();
        test_seed_collision();
        test_reset_midstream();
        test_zero_seed();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dom_share_feeder.md
# dom_share_feeder

Upstream feeder for the 3-share DOM AND gadget. It accepts unmasked operand bit pairs under a valid/ready handshake and splits each operand into three Boolean shares. It also supplies the gadget's three fresh refresh bits each cycle, using an internal seeded LFSR. A companion valid flag tracks the gadget's one-register latency so downstream logic knows when the recombined result is valid.

## Interface
- `LFSR_W`, 32: LFSR state width; must be ≥ 8.
- `WARMUP`, 16: number of LFSR advance cycles after a seed load before data is accepted; range 1–255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `seed_valid` in 1: seed offered.
- `seed` in LFSR_W: seed value.
- `seed_ready` out 1: seed accepted when both `seed_valid` and `seed_ready` are high.
- `in_valid` in 1: operand pair offered.
- `in_a` in 1: unmasked operand a.
- `in_b` in 1: unmasked operand b.
- `in_ready` out 1: operands accepted when both `in_valid` and `in_ready` are high.
- `is0`, `is1`, `is2` out 2 each: share k of {b, a}; bit 0 = a_k, bit 1 = b_k.
- `refreshing` out 3: refresh bits r0..r2 for the gadget.
- `share_valid` out 1: shares and refresh bits valid this cycle.
- `os_valid` out 1: gadget output `os` valid this cycle.
- `rng_fail` out 1: sticky health failure. Tied 0 unless `DOM_FEEDER_HEALTH_EN` is defined.

## Operation
- FSM states: UNSEEDED, SEEDING, READY.
- Reset values: state = UNSEEDED; LFSR = 0; warm-up counter = 0; every output register = 0 (`is*`, `refreshing`, `share_valid`, `os_valid`, `rng_fail`).
- `seed_ready` = 1 in UNSEEDED and READY, 0 in SEEDING.
- `in_ready` = (state == READY) && !`seed_valid`. A seed offered in the same cycle as operands wins.
- Seed handshake: load LFSR ← `seed` (with the zero-seed rule under Configuration), clear the counter, go to SEEDING. A reseed from READY aborts nothing, because each operand transaction completes in one cycle.
- SEEDING: LFSR advances every cycle and the counter increments. When the counter reaches WARMUP−1, go to READY on that edge.
- LFSR: Fibonacci, taps x^32+x^22+x^2+x+1 for LFSR_W = 32 (tap set as a package constant per width). The register advances 8 steps per clock in READY and SEEDING and holds in UNSEEDED.
- Draw: R[6:0] = the low 7 bits of the LFSR state before the advance.
- On an operand accept:
  - a0 = R0, a1 = R1, a2 = `in_a` ^ R0 ^ R1.
  - b0 = R2, b1 = R3, b2 = `in_b` ^ R2 ^ R3.
  - `refreshing` = R[6:4].
  - `share_valid` = 1.
- Cycles with no accept: `is*`, `refreshing` and `share_valid` are all registered to 0. Stale shares are never held.
- `os_valid` = `share_valid` delayed by one register, mirroring the gadget's share register.
- Invariants on every accept: is0 ^ is1 ^ is2 == {in_b, in_a}. Recombined `os` equals in_a & in_b on the `os_valid` cycle.

## Timing
- Operand accept at edge N: shares, refresh bits and `share_valid` are visible after edge N. The gadget captures at edge N+1, and `os_valid` is high after edge N+1.
- Throughput is one operand pair per cycle in READY, with no bubbles.
- Seed accept at edge S: `in_ready` first goes high after edge S+WARMUP (seed_valid low).
- A reseed in READY drops `in_ready` for WARMUP cycles. The pipeline flag already in flight still delivers `os_valid`.
- Asserting `rst_n` low mid-stream clears all state immediately, including the in-flight `os_valid`.

## Configuration
- `DOM_FEEDER_HEALTH_EN` undefined:
  - A zero seed is loaded with bit 0 forced to 1.
  - `rng_fail` = 0 constantly.
- `DOM_FEEDER_HEALTH_EN` defined:
  - A zero seed is not loaded; `rng_fail` sets and the state stays UNSEEDED.
  - A repetition counter sets `rng_fail` when 8 consecutive draws R[6:0] are identical in SEEDING or READY. That event forces UNSEEDED on the same edge.
  - `rng_fail` clears only on reset or on a subsequent accepted nonzero seed.

## Structure
- Package `dom_pkg`: FSM state enum, share count (3), LFSR tap constants per width, draw width (7).
- One sub-module, `dom_lfsr`: parameterised LFSR with a load port and an 8-step-per-clock advance.
- FSM, share split and valid pipeline live in `dom_share_feeder`.

## Test plan
- Reset, then seed 0x0000_0001, then hold `in_valid` = 0 → `in_ready` rises exactly 16 cycles after the seed accept, and all outputs stay 0 throughout.
- Sweep all four (a,b) pairs back-to-back after warm-up → on each `share_valid` cycle the XOR of the shares equals {b,a}; the recombined `os` equals a&b one cycle later with `os_valid` = 1.
- Drive `seed_valid` and `in_valid` in the same READY cycle → seed taken, operands not accepted, and `in_ready` stays 0 for 16 cycles.
- Pulse `rst_n` low between accept and the `os_valid` cycle → `os_valid`, `share_valid` and `is*` read 0 immediately, and the FSM is in UNSEEDED.
- Health build, seed 0 → `rng_fail` = 1 and `seed_ready` stays 1. A later seed 0xDEAD_BEEF clears `rng_fail`.
- Non-health build, seed 0 → normal warm-up with the LFSR seeded as 0x1, and `rng_fail` stays 0.
